// File: rtl/sub16u_apx_pipe.sv
// Two-stage handshaked approximate 16-bit unsigned subtractor. The low three result bits pass A through.
// Optional error monitor (err_mag, err_cnt) is built when SUB16U_ERRMON_EN is defined.
module sub16u_apx_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] O
`ifdef SUB16U_ERRMON_EN
  ,
  output logic [2:0]  err_mag,
  output logic [15:0] err_cnt
`endif
);

  logic        r_s1_valid;
  logic [5:0]  r_s1_a_hi;
  logic [5:0]  r_s1_b_hi;
  logic [9:0]  r_s1_o_lo;
  logic        r_s1_borrow;
  logic        r_s2_valid;
  logic [16:0] r_s2_o;

  logic        w_s2_load;
  logic        w_s1_adv;
  logic        w_accept;
  logic [7:0]  w_lo_diff;
  logic [6:0]  w_hi_diff;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_adv  = w_s2_load;
  assign in_ready  = !rst && (!r_s1_valid || w_s1_adv);
  assign w_accept  = in_valid && in_ready;

  // Bit 7 of the low difference is the borrow out of result bit 9.
  assign w_lo_diff = {1'b0, A[9:3]} - {1'b0, B[9:3]};
  assign w_hi_diff = {1'b0, r_s1_a_hi} - {1'b0, r_s1_b_hi} - {6'b0, r_s1_borrow};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_a_hi   <= '0;
      r_s1_b_hi   <= '0;
      r_s1_o_lo   <= '0;
      r_s1_borrow <= 1'b0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_accept) begin
        r_s1_a_hi   <= A[15:10];
        r_s1_b_hi   <= B[15:10];
        r_s1_o_lo   <= {w_lo_diff[6:0], A[2:0]};
        r_s1_borrow <= w_lo_diff[7];
      end
    end
  end

  // O only changes when a real result moves in, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_o     <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_o <= {w_hi_diff, r_s1_o_lo};
    end
  end

  assign out_valid = r_s2_valid;
  assign O         = r_s2_o;

`ifdef SUB16U_ERRMON_EN
  logic [2:0]  r_s1_err;
  logic [2:0]  r_s2_err;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_err  <= '0;
      r_s2_err  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_accept) r_s1_err <= B[2:0];
      if (w_s2_load && r_s1_valid) r_s2_err <= r_s1_err;
      if (r_s2_valid && out_ready && (r_s2_err != 3'd0) && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign err_mag = r_s2_err;
  assign err_cnt = r_err_cnt;
`else
  logic w_unused_b_lo;
  assign w_unused_b_lo = ^B[2:0];
`endif

endmodule
